// File: rtl/line_fill_memory_pkg.sv
// Shared constants and FSM encoding for the line-fill main-memory stage.
package mem_pkg;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 8;
  localparam int LINE_WORDS = 4;
  localparam int OFF_W      = $clog2(LINE_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_BURST,
    WR_WAIT,
    ACK_WR
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/line_fill_memory_mem_array.sv
// Backing store: synchronous write, asynchronous read, word i powers up holding i.
module mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] word_bus [DEPTH];

  // Per-word registers so each one can carry its own power-up value.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    logic [DATA_W-1:0] word_q = DATA_W'(gi);

    always_ff @(posedge clk) begin
      if (we && (waddr == ADDR_W'(gi))) begin
        word_q <= wdata;
      end
    end

    assign word_bus[gi] = word_q;
  end

  assign rdata = word_bus[raddr];

endmodule

// File: rtl/line_fill_memory.sv
// Main-memory stage: critical-word-first line fills and write-through stores with fixed latency.
module line_fill_memory #(
  parameter int ADDR_W     = mem_pkg::ADDR_W,
  parameter int DATA_W     = mem_pkg::DATA_W,
  parameter int LINE_WORDS = mem_pkg::LINE_WORDS,
  parameter int RD_LAT     = 3,
  parameter int WR_LAT     = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mem_req,
  input  logic                          mem_we,
  input  logic [ADDR_W-1:0]             mem_addr,
  input  logic [DATA_W-1:0]             mem_wdata,
  output logic                          mem_busy,
  output logic                          mem_rvalid,
  output logic [DATA_W-1:0]             mem_rdata,
  output logic [$clog2(LINE_WORDS)-1:0] mem_beat,
  output logic                          mem_ack
);
  import mem_pkg::*;

  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam int CNT_W  = $clog2(max_int(RD_LAT, WR_LAT) + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BEAT_W-1:0]   off_q, off_d;
  logic [BEAT_W-1:0]   nbeat_q, nbeat_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                ack_q, ack_d;

  logic                arr_we;
  logic                emit;
  logic [ADDR_W-1:0]   arr_raddr;
  logic [DATA_W-1:0]   arr_rdata;

  // Offset wraps inside the line, so the upper address bits never change during a burst.
  assign arr_raddr = {addr_q[ADDR_W-1:BEAT_W], off_q};

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (addr_q),
    .wdata (wdata_q),
    .raddr (arr_raddr),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    off_d    = off_q;
    nbeat_d  = nbeat_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    busy_d   = 1'b0;
    rvalid_d = 1'b0;
    rdata_d  = '0;
    beat_d   = '0;
    ack_d    = 1'b0;
    arr_we   = 1'b0;
    emit     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mem_req) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          off_d   = mem_addr[BEAT_W-1:0];
          cnt_d   = '0;
          nbeat_d = '0;
          busy_d  = 1'b1;
          state_d = mem_we ? WR_WAIT : RD_WAIT;
        end
      end
      RD_WAIT: begin
        busy_d = 1'b1;
        if (cnt_q == CNT_W'(RD_LAT - 1)) begin
          emit    = 1'b1;
          state_d = RD_BURST;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RD_BURST: begin
        // Ack rides on the last beat; once it is showing, the burst is over.
        if (ack_q) begin
          state_d = IDLE;
        end else begin
          busy_d = 1'b1;
          emit   = 1'b1;
        end
      end
      WR_WAIT: begin
        busy_d = 1'b1;
        if (cnt_q == CNT_W'(WR_LAT - 1)) begin
          arr_we  = 1'b1;
          ack_d   = 1'b1;
          state_d = ACK_WR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACK_WR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (emit) begin
      rvalid_d = 1'b1;
      rdata_d  = arr_rdata;
      beat_d   = off_q;
      off_d    = off_q + 1'b1;
      nbeat_d  = nbeat_q + 1'b1;
      ack_d    = (nbeat_q == BEAT_W'(LINE_WORDS - 1));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      off_q    <= '0;
      nbeat_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      beat_q   <= '0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      off_q    <= off_d;
      nbeat_q  <= nbeat_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      beat_q   <= beat_d;
      ack_q    <= ack_d;
    end
  end

  assign mem_busy   = busy_q;
  assign mem_rvalid = rvalid_q;
  assign mem_rdata  = rdata_q;
  assign mem_beat   = beat_q;
  assign mem_ack    = ack_q;

endmodule

// File: tb/tb_line_fill_memory.sv
// Scoreboard bench: the driver predicts every beat/ack and its cycle; a negedge monitor pops and compares.
module tb_line_fill_memory;

  localparam int RD_LAT = 3;
  localparam int WR_LAT = 2;
  localparam int LW     = 4;

  typedef struct {
    int         cyc;
    bit         rv;
    logic [7:0] data;
    logic [1:0] beat;
    bit         ack;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mem_req = 1'b0;
  logic       mem_we = 1'b0;
  logic [7:0] mem_addr = '0;
  logic [7:0] mem_wdata = '0;
  logic       mem_busy;
  logic       mem_rvalid;
  logic [7:0] mem_rdata;
  logic [1:0] mem_beat;
  logic       mem_ack;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   next_accept = 0;
  int   busy_lo = 1;
  int   busy_hi = 0;
  bit   hold_prev = 1'b0;
  exp_t exp_q[$];
  logic [7:0] model [256];

  line_fill_memory #(
    .ADDR_W     (8),
    .DATA_W     (8),
    .LINE_WORDS (LW),
    .RD_LAT     (RD_LAT),
    .WR_LAT     (WR_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_busy   (mem_busy),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_beat   (mem_beat),
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, req, cyc);
    end
  endtask

  // Monitor: runs mid-cycle, so every output has settled since the last rising edge.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      chk("missed_event_cycle", cyc, e.cyc);
    end
    chk("busy", int'(mem_busy), int'(cyc >= busy_lo && cyc <= busy_hi));
    if (!mem_rvalid) begin
      chk("rdata_idle_zero", int'(mem_rdata), 0);
      chk("beat_idle_zero", int'(mem_beat), 0);
    end
    if (mem_rvalid || mem_ack) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("event_cycle", cyc, e.cyc);
        chk("rvalid", int'(mem_rvalid), int'(e.rv));
        chk("rdata", int'(mem_rdata), int'(e.data));
        chk("beat", int'(mem_beat), int'(e.beat));
        chk("ack", int'(mem_ack), int'(e.ack));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, int'(mem_busy), 0);
    chk({tag, "_rvalid"}, int'(mem_rvalid), 0);
    chk({tag, "_rdata"}, int'(mem_rdata), 0);
    chk({tag, "_beat"}, int'(mem_beat), 0);
    chk({tag, "_ack"}, int'(mem_ack), 0);
  endtask

  // Called at posedge+1. Junk is driven while the DUT is busy (it must be ignored);
  // the real request goes out so that it is sampled by the predicted acceptance edge.
  task automatic do_txn(input bit we, input logic [7:0] addr, input logic [7:0] wd,
                        input int gap, input bit hold, input bit commit);
    int   a;
    int   off;
    exp_t e;
    while (cyc + 1 < next_accept + gap) begin
      if (!hold_prev) begin
        mem_we    = 1'($urandom);
        mem_addr  = 8'($urandom);
        mem_wdata = 8'($urandom);
        mem_req   = (cyc + 1 <= next_accept - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      @(posedge clk); #1;
    end
    mem_req   = 1'b1;
    mem_we    = we;
    mem_addr  = addr;
    mem_wdata = wd;
    a = cyc + 1;
    if (!we) begin
      for (int k = 0; k < LW; k++) begin
        off    = (int'(addr) + k) % LW;
        e.cyc  = a + RD_LAT + k;
        e.rv   = 1'b1;
        e.data = model[(int'(addr) / LW) * LW + off];
        e.beat = 2'(off);
        e.ack  = (k == LW - 1);
        exp_q.push_back(e);
      end
      busy_lo     = a;
      busy_hi     = a + RD_LAT + LW - 1;
      next_accept = a + RD_LAT + LW + 1;
    end else begin
      e.cyc  = a + WR_LAT;
      e.rv   = 1'b0;
      e.data = 8'h00;
      e.beat = 2'd0;
      e.ack  = 1'b1;
      exp_q.push_back(e);
      if (commit) model[addr] = wd;
      busy_lo     = a;
      busy_hi     = a + WR_LAT;
      next_accept = a + WR_LAT + 2;
    end
    $display("txn cyc=%0d we=%0d addr=%02h wdata=%02h hold=%0d", a, we, addr, wd, hold);
    hold_prev = hold;
    @(posedge clk); #1;
    if (!hold) mem_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model[i] = 8'(i);

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    next_accept = cyc + 1;

    // Directed cases
    do_txn(1'b0, 8'h01, 8'h00, 0, 1'b0, 1'b1);
    do_txn(1'b1, 8'h05, 8'h0B, 0, 1'b0, 1'b1);
    do_txn(1'b0, 8'h05, 8'h00, 0, 1'b0, 1'b1);
    do_txn(1'b0, 8'hFF, 8'h00, 1, 1'b0, 1'b1);
    do_txn(1'b0, 8'h20, 8'h00, 0, 1'b1, 1'b1);
    do_txn(1'b0, 8'h20, 8'h00, 0, 1'b0, 1'b1);

    // Reset in cycle 1 of a write: the store must never land.
    do_txn(1'b1, 8'h09, 8'h55, 1, 1'b0, 1'b0);
    rst = 1'b0;
    exp_q.delete();
    busy_lo = 1;
    busy_hi = 0;
    #1;
    check_all_zero("mid_write_reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_all_zero("held_reset");
    rst = 1'b1;
    hold_prev = 1'b0;
    next_accept = cyc + 1;
    do_txn(1'b0, 8'h09, 8'h00, 0, 1'b0, 1'b1);

    // Random mix; addresses confined to a few lines so writes get read back.
    for (int n = 0; n < 40; n++) begin
      do_txn(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom),
             $urandom_range(0, 2), 1'b0, 1'b1);
    end

    for (int w = 0; w < 100 && cyc < next_accept + 2; w++) begin
      @(posedge clk); #1;
    end
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish cyc=%0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
